gray_decode_arbiter: RTL and testbench

//   Shares one combinational gray_to_binary converter between N_REQ requesters.

---
 rtl/gray_decode_arbiter_pkg.sv | 14 +
 rtl/gray_decode_arbiter_arb.sv | 34 +++
 rtl/gray_decode_arbiter_g2b.sv | 18 +
 rtl/gray_decode_arbiter.sv | 100 ++++++++++
 tb/tb_gray_decode_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/gray_decode_arbiter_pkg.sv
// Shared defaults and output-stage state encoding for gray_decode_arbiter.
package gray_decode_arbiter_pkg;

  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned W_DEFAULT     = 4;
  localparam int unsigned IDW_DEFAULT   = $clog2(N_REQ_DEFAULT);

  // Single-entry output stage occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

endpackage

// File: rtl/gray_decode_arbiter_arb.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after ptr.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   gnt_idx,
  output logic             gnt_any
);

  logic [IDW-1:0] idx;

  // Scan requesters starting at ptr, wrapping modulo N_REQ; first hit wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    if (en) begin
      for (int unsigned off = 0; off < N_REQ; off++) begin
        idx = IDW'((32'(ptr) + off) % N_REQ);
        if (!gnt_any && req[idx]) begin
          grant[idx] = 1'b1;
          gnt_idx    = idx;
          gnt_any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gray_decode_arbiter_g2b.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of the
// gray bits at and above its position.
module gray_to_binary #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  // Prefix-XOR from the MSB down, written per bit to avoid a self-referencing chain.
  always_comb begin
    b = '0;
    for (int unsigned k = 0; k < W; k++) begin
      b[k] = ^(g >> k);
    end
  end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Shares one gray-to-binary converter between N_REQ requesters using
// round-robin arbitration and a single-entry registered output stage.
module gray_decode_arbiter
  import gray_decode_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_gray,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_binary,
  output logic [IDW-1:0]     out_id
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  ostate_t        state, state_nx;
  logic [IDW-1:0] rr_ptr, rr_ptr_nx;
  logic [W-1:0]   bin_nx;
  logic [IDW-1:0] id_nx;

  logic             can_accept;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [W-1:0]     sel_gray;
  logic [W-1:0]     sel_bin;

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  // Gating the arbiter with rst_n keeps req_ready low throughout reset.
  assign req_ready  = grant;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .en      (rst_n && can_accept),
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Select the granted requester's code for the shared decoder.
  always_comb begin
    sel_gray = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_gray = req_gray[i*W +: W];
      end
    end
  end

  gray_to_binary #(
    .W (W)
  ) u_g2b (
    .g (sel_gray),
    .b (sel_bin)
  );

  // Next-state: load on grant, drain when consumer takes the result, else hold.
  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    bin_nx    = out_binary;
    id_nx     = out_id;
    if (gnt_any) begin
      state_nx  = FULL;
      bin_nx    = sel_bin;
      id_nx     = gnt_idx;
      rr_ptr_nx = (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);
    end else if (out_valid && out_ready) begin
      state_nx = EMPTY;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rr_ptr     <= '0;
      out_binary <= '0;
      out_id     <= '0;
    end else begin
      state      <= state_nx;
      rr_ptr     <= rr_ptr_nx;
      out_binary <= bin_nx;
      out_id     <= id_nx;
    end
  end

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Self-checking bench for gray_decode_arbiter (N_REQ=4, W=4).
module tb_gray_decode_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_gray;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_binary;
  logic [1:0]  out_id;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         known = 1'b0;
  bit         m_valid;
  logic [3:0] m_bin;
  logic [1:0] m_id;
  int         m_ptr;
  logic [3:0] tbl [16];
  logic [3:0] last_ready;

  gray_decode_arbiter #(
    .N_REQ (4),
    .W     (4),
    .IDW   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_binary (out_binary),
    .out_id     (out_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int off = 0; off < 4; off++) begin
      if (v[(ptr + off) % 4]) return (ptr + off) % 4;
    end
    return -1;
  endfunction

  // Drive one cycle at negedge, check against model, advance model at posedge.
  task automatic step(input logic rst, input logic [3:0] v, input logic [15:0] g,
                      input logic ordy);
    int gi;
    logic [3:0] expr;
    rst_n = rst; req_valid = v; req_gray = g; out_ready = ordy;
    #1;
    gi = (rst && (!m_valid || ordy)) ? pick(v, m_ptr) : -1;
    expr = (gi >= 0) ? 4'(1 << gi) : 4'b0000;
    chk("req_ready", {4'b0, req_ready}, {4'b0, expr});
    last_ready = req_ready;
    if (known) begin
      chk("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
      chk("out_binary", {4'b0, out_binary}, {4'b0, m_bin});
      chk("out_id", {6'b0, out_id}, {6'b0, m_id});
    end
    @(posedge clk);
    if (!rst) begin
      m_valid = 1'b0; m_bin = '0; m_id = '0; m_ptr = 0;
    end else if (gi >= 0) begin
      m_bin = tbl[g[gi*4 +: 4]];
      m_id = 2'(gi);
      m_valid = 1'b1;
      m_ptr = (gi + 1) % 4;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    known = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] gb;
    // Inverse table built from the forward encoding gray = b ^ (b >> 1).
    for (int b = 0; b < 16; b++) begin
      gb = 4'(b);
      tbl[gb ^ (gb >> 1)] = gb;
    end
    m_valid = 1'b0; m_bin = '0; m_id = '0; m_ptr = 0;
    rst_n = 1'b0; req_valid = '0; req_gray = '0; out_ready = 1'b0;
    @(negedge clk);

    // 1 Reset held with all requests valid
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 16'($urandom), 1'b1);
      chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
      chk("rst_out_binary", {4'b0, out_binary}, 8'h00);
      chk("rst_out_id", {6'b0, out_id}, 8'h00);
    end

    // 2 Single request
    step(1'b1, 4'b0001, 16'h000D, 1'b1);
    chk("single_grant", {4'b0, last_ready}, 8'h01);
    chk("single_bin", {4'b0, out_binary}, 8'h09);
    chk("single_id", {6'b0, out_id}, 8'h00);
    chk("single_valid", {7'b0, out_valid}, 8'h01);

    // 3 Round-robin with all valid
    step(1'b0, 4'b0000, 16'h0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b1111, 16'h3821, 1'b1);
      chk("rr_grant", {4'b0, last_ready}, 8'(1 << (k % 4)));
      if (k == 2) begin
        chk("rr_bin2", {4'b0, out_binary}, 8'h0F);
        chk("rr_id2", {6'b0, out_id}, 8'h02);
      end
    end

    // 4 Backpressure then same-cycle refill
    step(1'b0, 4'b0000, 16'h0000, 1'b1);
    step(1'b1, 4'b0001, 16'h000F, 1'b1);
    chk("bp_bin", {4'b0, out_binary}, 8'h0A);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b1111, 16'($urandom), 1'b0);
      chk("bp_ready", {4'b0, last_ready}, 8'h00);
      chk("bp_hold_bin", {4'b0, out_binary}, 8'h0A);
      chk("bp_hold_valid", {7'b0, out_valid}, 8'h01);
    end
    step(1'b1, 4'b1111, 16'h5555, 1'b1);
    chk("bp_release_grant", {4'b0, last_ready}, 8'h02);
    chk("bp_no_bubble", {7'b0, out_valid}, 8'h01);

    // 5 Wrap and skip
    step(1'b0, 4'b0000, 16'h0000, 1'b1);
    step(1'b1, 4'b0100, 16'h0000, 1'b1);
    step(1'b1, 4'b0101, 16'h0000, 1'b1);
    chk("wrap_grant0", {4'b0, last_ready}, 8'h01);
    step(1'b1, 4'b0101, 16'h0000, 1'b1);
    chk("skip_grant2", {4'b0, last_ready}, 8'h04);

    // 6 Mid-operation reset, then exhaustive decode sweep on requester 1
    step(1'b1, 4'b1000, 16'h7000, 1'b0);
    step(1'b1, 4'b1000, 16'h7000, 1'b0);
    step(1'b0, 4'b1111, 16'hFFFF, 1'b0);
    chk("midrst_valid", {7'b0, out_valid}, 8'h00);
    for (int g = 0; g < 16; g++) begin
      step(1'b1, 4'b0010, 16'(g << 4), 1'b1);
      chk("sweep_grant", {4'b0, last_ready}, 8'h02);
      gb = 4'(g);
      chk("sweep_bin", {4'b0, out_binary}, {4'b0, tbl[gb]});
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 30) != 0), 4'($urandom), 16'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
